// File: rtl/ping_pong_ram.sv
// Two-bank ping-pong buffer: the producer streams into one bank while the consumer reads the other.
// Optional drop-and-count overflow mode is enabled with `define PPB_OVERFLOW_CNT_EN.
module ping_pong_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDRW      = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDRW:0]        wr_fill,
  output logic                  rd_bank_valid,
  input  logic                  rd_en,
  input  logic [ADDRW-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  input  logic                  rd_done
`ifdef PPB_OVERFLOW_CNT_EN
  ,output logic [15:0]          overflow_cnt
`endif
);

  localparam int                IDXW     = $clog2(2 * DEPTH);
  localparam logic [ADDRW:0]    LP_DEPTH = (ADDRW + 1)'(DEPTH);
  localparam logic [ADDRW-1:0]  LP_LAST  = ADDRW'(DEPTH - 1);
  localparam logic [IDXW-1:0]   LP_BANK1 = IDXW'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [2*DEPTH];
  logic [1:0]            r_full;
  logic                  r_wb;
  logic                  r_rb;
  logic [ADDRW-1:0]      r_wptr;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_data_valid;

  logic                  w_wr_fire;
  logic                  w_wr_last;
  logic                  w_rd_fire;
  logic                  w_release;
  logic                  w_addr_ok;
  logic [1:0]            w_full_nxt;
  logic [IDXW-1:0]       w_wr_idx;
  logic [IDXW-1:0]       w_rd_idx;

  assign w_wr_fire = wr_valid && !r_full[r_wb];
  assign w_wr_last = w_wr_fire && (r_wptr == LP_LAST);
  assign w_rd_fire = rd_en && r_full[r_rb];
  assign w_release = rd_done && r_full[r_rb];
  assign w_addr_ok = ({1'b0, rd_addr} < LP_DEPTH);

  // Bank 1 starts at word DEPTH, so non-power-of-two depths waste no storage.
  assign w_wr_idx = r_wb ? (LP_BANK1 + IDXW'(r_wptr))  : IDXW'(r_wptr);
  assign w_rd_idx = r_rb ? (LP_BANK1 + IDXW'(rd_addr)) : IDXW'(rd_addr);

  // Fill completion and release always hit different banks, so both updates apply.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_last) w_full_nxt[r_wb] = 1'b1;
    if (w_release) w_full_nxt[r_rb] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_full <= 2'b00;
      r_wb   <= 1'b0;
      r_rb   <= 1'b0;
      r_wptr <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_fire) begin
        if (w_wr_last) begin
          r_wptr <= '0;
          r_wb   <= ~r_wb;
        end else begin
          r_wptr <= r_wptr + 1'b1;
        end
      end
      if (w_release) r_rb <= ~r_rb;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[w_wr_idx] <= wr_data;
  end

  // Registered read port; a read issued with rd_done still sees the bank being released.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_data       <= '0;
      r_rd_data_valid <= 1'b0;
    end else begin
      r_rd_data_valid <= w_rd_fire;
      if (w_rd_fire) r_rd_data <= w_addr_ok ? r_mem[w_rd_idx] : '0;
    end
  end

`ifdef PPB_OVERFLOW_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ovf_cnt <= '0;
    end else if (wr_valid && r_full[r_wb] && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign wr_ready     = 1'b1;
  assign overflow_cnt = r_ovf_cnt;
`else
  assign wr_ready = ~r_full[r_wb];
`endif

  assign wr_fill       = {1'b0, r_wptr};
  assign rd_bank_valid = r_full[r_rb];
  assign rd_data       = r_rd_data;
  assign rd_data_valid = r_rd_data_valid;

endmodule

// File: tb/tb_ping_pong_ram.sv
// Directed bench for ping_pong_ram: expected read words are queued at issue time and
// a monitor pops and compares them whenever rd_data_valid is seen.
module tb_ping_pong_ram;

  logic        clk;
  logic        resetn;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [5:0]  wr_fill;
  logic        rd_bank_valid;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        rd_done;
`ifdef PPB_OVERFLOW_CNT_EN
  logic [15:0] overflow_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  ping_pong_ram #(.DATA_WIDTH(32), .DEPTH(16), .ADDRW(5)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .wr_fill       (wr_fill),
    .rd_bank_valid (rd_bank_valid),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .rd_done       (rd_done)
`ifdef PPB_OVERFLOW_CNT_EN
    ,.overflow_cnt (overflow_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int d);
    wr_valid = 1'b1;
    wr_data  = 32'(d);
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input int a, input int e);
    rd_en   = 1'b1;
    rd_addr = 5'(a);
    exp_q.push_back(32'(e));
    cyc();
    rd_en = 1'b0;
    check("rd_latency", 32'(rd_data_valid), 32'd1);
  endtask

  // Monitor: every valid read result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resetn && rd_data_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rd_valid: got data 0x%0h, expected no result", rd_data);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    resetn = 1'b0; wr_valid = 1'b0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
    cyc(); cyc();
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_wr_fill", 32'(wr_fill), 32'd0);
    check("rst_rd_bank_valid", 32'(rd_bank_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_rd_data_valid", 32'(rd_data_valid), 32'd0);
    resetn = 1'b1;
    cyc();

    // Basic handoff: bank 0 gets 0..15
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'(i);
      cyc();
      if (i == 14) begin
        check("fill15_bank_valid", 32'(rd_bank_valid), 32'd0);
        check("fill15_wr_fill", 32'(wr_fill), 32'd15);
      end
    end
    wr_valid = 1'b0;
    check("handoff_bank_valid", 32'(rd_bank_valid), 32'd1);
    check("handoff_wr_ready", 32'(wr_ready), 32'd1);
    check("handoff_wr_fill", 32'(wr_fill), 32'd0);
    for (int i = 0; i < 16; i++) rd(i, i);

    // Stall: bank 1 gets 100..115, both banks then full
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'(100 + i);
      cyc();
    end
    check("stall_wr_ready", 32'(wr_ready), 32'd0);
    check("stall_wr_fill", 32'(wr_fill), 32'd0);
    wr_data = 32'd999;
    cyc(); cyc();
    check("stall_hold_wr_ready", 32'(wr_ready), 32'd0);
    check("stall_hold_wr_fill", 32'(wr_fill), 32'd0);
    wr_data = 32'd200;
    rd_done = 1'b1;
    cyc();
    rd_done = 1'b0;
    check("release_wr_ready", 32'(wr_ready), 32'd1);
    check("release_bank_valid", 32'(rd_bank_valid), 32'd1);
    check("release_wr_fill", 32'(wr_fill), 32'd0);
    cyc();
    wr_valid = 1'b0;
    check("word33_wr_fill", 32'(wr_fill), 32'd1);
    rd(0, 100);
    rd(7, 107);
    rd(15, 115);

    // Simultaneous fill completion, release and read
    for (int i = 1; i < 15; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'(200 + i);
      cyc();
    end
    wr_data = 32'd215;
    rd_done = 1'b1;
    rd_en   = 1'b1;
    rd_addr = 5'd3;
    exp_q.push_back(32'd103);
    cyc();
    wr_valid = 1'b0; rd_done = 1'b0; rd_en = 1'b0;
    check("simul_bank_valid", 32'(rd_bank_valid), 32'd1);
    check("simul_wr_ready", 32'(wr_ready), 32'd1);
    check("simul_rd_valid", 32'(rd_data_valid), 32'd1);
    rd(0, 200);
    rd(1, 201);
    rd(15, 215);

    // Release, then an idle read must produce nothing
    rd_done = 1'b1;
    cyc();
    rd_done = 1'b0;
    check("empty_bank_valid", 32'(rd_bank_valid), 32'd0);
    rd_en   = 1'b1;
    rd_addr = 5'd0;
    cyc();
    rd_en = 1'b0;
    check("idle_rd_valid", 32'(rd_data_valid), 32'd0);
    check("idle_rd_data_hold", rd_data, 32'd215);

    // Mid-fill reset
    for (int i = 0; i < 7; i++) wr(300 + i);
    check("partial_wr_fill", 32'(wr_fill), 32'd7);
    #2 resetn = 1'b0;
    #1;
    check("midrst_wr_fill", 32'(wr_fill), 32'd0);
    check("midrst_wr_ready", 32'(wr_ready), 32'd1);
    check("midrst_bank_valid", 32'(rd_bank_valid), 32'd0);
    check("midrst_rd_data", rd_data, 32'd0);
    cyc();
    resetn = 1'b1;
    cyc();
    wr(400);
    check("restart_wr_fill", 32'(wr_fill), 32'd1);
    for (int i = 1; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'(400 + i);
      cyc();
    end
    wr_valid = 1'b0;
    check("restart_bank_valid", 32'(rd_bank_valid), 32'd1);
    rd(0, 400);
    rd(6, 406);
    rd(15, 415);
    rd(16, 0);
    rd(20, 0);
    rd(31, 0);

    // Both banks full again, then push extra words
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'(500 + i);
      cyc();
    end
    wr_valid = 1'b0;
`ifdef PPB_OVERFLOW_CNT_EN
    check("ovf_wr_ready", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 5; i++) wr(32'hDEAD);
    check("ovf_count", 32'(overflow_cnt), 32'd5);
`else
    check("full2_wr_ready", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 5; i++) wr(32'hDEAD);
`endif
    check("full2_wr_fill", 32'(wr_fill), 32'd0);
    rd(0, 400);
    rd(15, 415);
    rd_done = 1'b1;
    cyc();
    rd_done = 1'b0;
    rd(0, 500);
    rd(15, 515);

    cyc(); cyc();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
